pipe_front_regs: RTL

//  Consumer side of the hazard interface: PC register, IF/ID and ID/EX pipeline registers of the 5-stage RV32I core.

---
 rtl/pipe_front_regs_pkg.sv | 51 +++++
 rtl/pipe_front_regs_if.sv | 26 ++
 rtl/pipe_front_regs_pipe_reg.sv | 25 ++
 rtl/pipe_front_regs.sv | 120 ++++++++++++
 4 files changed

// File: rtl/pipe_front_regs_pkg.sv
// Shared constants and register-bundle types for the RV32I front-end pipeline registers.
package riscv_pipe_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CTRL_W    = 8;
    localparam int unsigned CNT_W     = 16;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    // Packed decode control bundle; result_src sits in the low bits so ctrl[1:0] is result_src.
    typedef struct packed {
        logic       jump;
        logic [2:0] alu_ctrl;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        ctrl_t           ctrl;
        logic            valid;
    } id_ex_t;

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/pipe_front_regs_if.sv
// Hazard interface: the hazard unit (master) drives stalls/flushes, the pipeline registers (slave)
// report the register addresses and result source it needs for forwarding and load-use detection.
interface pipe_front_regs_if;

    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic [4:0] rd_e;
    logic [1:0] result_src_e;

    modport master (
        output stall_f, stall_d, flush_d, flush_e,
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e
    );

    modport slave (
        input  stall_f, stall_d, flush_d, flush_e,
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e
    );

endinterface

// File: rtl/pipe_front_regs_pipe_reg.sv
// Generic pipeline register: async reset and synchronous clear both load RST_VAL; clear beats enable.
module pipe_reg #(
    parameter int unsigned W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register with clear-over-enable priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_front_regs.sv
// PC register, IF/ID and ID/EX registers of the 5-stage RV32I core, with saturating hazard event counters.
module pipe_front_regs #(
    parameter int unsigned     XLEN      = riscv_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = riscv_pipe_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = riscv_pipe_pkg::NOP_INSTR,
    parameter int unsigned     CTRL_W    = riscv_pipe_pkg::CTRL_W,
    parameter int unsigned     CNT_W     = riscv_pipe_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_front_regs_if.slave  hz,
    input  logic              pcsrc_e,
    input  logic [XLEN-1:0]   pc_target_e,
    input  logic [31:0]       instr_f,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   imm_ext_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    output logic [XLEN-1:0]   pc_f,
    output logic [31:0]       instr_d,
    output logic [XLEN-1:0]   pc_d,
    output logic [XLEN-1:0]   pc_plus4_d,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_ext_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              valid_d,
    output logic              valid_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import riscv_pipe_pkg::*;

    localparam int unsigned IFID_W = 32 + 2 * XLEN + 1;
    localparam int unsigned IDEX_W = 15 + 5 * XLEN + CTRL_W + 1;
    localparam logic [IFID_W-1:0] IFID_RST = {NOP_INSTR, {(2 * XLEN + 1){1'b0}}};
    localparam logic [XLEN-1:0]   PC_STEP  = {{(XLEN - 3){1'b0}}, 3'd4};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};

    logic [XLEN-1:0]   pc_plus4_f;
    logic [IFID_W-1:0] if_id_d;
    logic [IFID_W-1:0] if_id_q;
    logic [IDEX_W-1:0] id_ex_d;
    logic [IDEX_W-1:0] id_ex_q;
    logic [4:0]        rs1_e;
    logic [4:0]        rs2_e;
    logic [4:0]        rd_e;

    assign pc_plus4_f = pc_f + PC_STEP;

    // PC: a redirect is taken even while fetch is stalled so it can never be lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f <= RESET_PC;
        end else if (pcsrc_e) begin
            pc_f <= pc_target_e;
        end else if (!hz.stall_f) begin
            pc_f <= pc_plus4_f;
        end
    end

    assign if_id_d = {instr_f, pc_f, pc_plus4_f, 1'b1};

    pipe_reg #(
        .W       (IFID_W),
        .RST_VAL (IFID_RST)
    ) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!hz.stall_d),
        .clr   (hz.flush_d),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign {instr_d, pc_d, pc_plus4_d, valid_d} = if_id_q;
    assign hz.rs1_d = rs1_of(instr_d);
    assign hz.rs2_d = rs2_of(instr_d);

    // A stalled decode stage must not also advance into EX, so stall_d bubbles ID/EX.
    assign id_ex_d = {rs1_of(instr_d), rs2_of(instr_d), rd_of(instr_d), rd1_d, rd2_d, imm_ext_d,
                      pc_d, pc_plus4_d, ctrl_d, valid_d};

    pipe_reg #(
        .W       (IDEX_W),
        .RST_VAL ('0)
    ) u_id_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (hz.flush_e | hz.stall_d),
        .d     (id_ex_d),
        .q     (id_ex_q)
    );

    assign {rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, ctrl_e, valid_e} = id_ex_q;
    assign hz.rs1_e        = rs1_e;
    assign hz.rs2_e        = rs2_e;
    assign hz.rd_e         = rd_e;
    assign hz.result_src_e = ctrl_e[1:0];

    // Saturating stall/flush event counters for debug visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.stall_d && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if ((hz.flush_d || hz.flush_e) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule
